// File: rtl/spi_master_core_if.sv
// Command-side handshake between the UART/SPI command controller and spi_master_core.
interface spi_master_core_if #(
   parameter int SPI_ADDR_WIDTH = 6,
   parameter int SPI_DATA_WIDTH = 20
);
   logic                      i_spi_start;
   logic                      i_spi_rw;
   logic [SPI_ADDR_WIDTH-1:0] i_spi_addr;
   logic [SPI_DATA_WIDTH-1:0] i_spi_wdata;
   logic                      o_spi_data_valid;
   logic [SPI_DATA_WIDTH-1:0] o_spi_rdata;
   logic                      o_busy;

   modport master (output i_spi_start, i_spi_rw, i_spi_addr, i_spi_wdata,
                   input  o_spi_data_valid, o_spi_rdata, o_busy);
   modport slave  (input  i_spi_start, i_spi_rw, i_spi_addr, i_spi_wdata,
                   output o_spi_data_valid, o_spi_rdata, o_busy);
endinterface

// File: rtl/spi_master_core.sv
// Mode-0 SPI master: shifts {rw, addr, wdata} frames MSB first and returns captured read words.
// Optional macro SPI_START_QUEUE_EN adds a one-deep queue for starts arriving mid-frame.
module spi_master_core #(
   parameter int SPI_ADDR_WIDTH = 6,
   parameter int SPI_DATA_WIDTH = 20,
   parameter int CLK_DIV        = 4
) (
   input  logic             i_clk_sys,
   input  logic             i_rst,
   spi_master_core_if.slave io_cmd,
   output logic             o_spi_sclk,
   output logic             o_spi_cs_n,
   output logic             o_spi_mosi,
   input  logic             i_spi_miso
);
   localparam int FRAME_W = 1 + SPI_ADDR_WIDTH + SPI_DATA_WIDTH;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [4:0]       BIT_LAST = 5'(FRAME_W - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;

   logic [2:0]                r_state;
   logic [DIV_W-1:0]          r_div;
   logic [4:0]                r_bit;
   logic [FRAME_W-1:0]        r_shift;
   logic [SPI_DATA_WIDTH-1:0] r_cap;
   logic                      r_rw;
   logic                      r_sclk;
   logic                      r_cs_n;
   logic                      r_busy;
   logic                      r_valid;
   logic [SPI_DATA_WIDTH-1:0] r_rdata;

   logic [SPI_DATA_WIDTH-1:0] w_wdata;
   logic [FRAME_W-1:0]        w_frame;
   logic                      w_div_end;
   logic                      w_queue;

   // Read frames shift zeros in the data field.
   assign w_wdata   = io_cmd.i_spi_rw ? '0 : io_cmd.i_spi_wdata;
   assign w_frame   = {io_cmd.i_spi_rw, io_cmd.i_spi_addr, w_wdata};
   assign w_div_end = (r_div == DIV_LAST);

`ifdef SPI_START_QUEUE_EN
   logic               r_pend_vld;
   logic [FRAME_W-1:0] r_pend_frame;

   // DONE chains into the gap/accept path when a start is pending or arrives right then.
   assign w_queue = r_pend_vld | io_cmd.i_spi_start;

   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         r_pend_vld   <= 1'b0;
         r_pend_frame <= '0;
      end else if (r_state == S_GAP && w_div_end) begin
         r_pend_vld <= 1'b0;
      end else if (io_cmd.i_spi_start && r_state != S_IDLE && !r_pend_vld) begin
         r_pend_vld   <= 1'b1;
         r_pend_frame <= w_frame;
      end
   end
`else
   assign w_queue = 1'b0;
`endif

   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_cap   <= '0;
         r_rw    <= 1'b0;
         r_sclk  <= 1'b0;
         r_cs_n  <= 1'b1;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_cmd.i_spi_start) begin
                  r_shift <= w_frame;
                  r_rw    <= w_frame[FRAME_W-1];
                  r_cs_n  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_div   <= '0;
                  r_bit   <= '0;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_div_end) begin
                  r_div   <= '0;
                  r_state <= S_SHIFT;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_SHIFT: begin
               if (!w_div_end) begin
                  r_div <= r_div + 1'b1;
               end else begin
                  r_div <= '0;
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                     r_cap  <= {r_cap[SPI_DATA_WIDTH-2:0], i_spi_miso};
                  end else begin
                     r_sclk <= 1'b0;
                     if (r_bit == BIT_LAST) begin
                        r_state <= S_HOLD;
                     end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                     end
                  end
               end
            end
            S_HOLD: begin
               if (w_div_end) begin
                  r_div   <= '0;
                  r_cs_n  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_DONE: begin
               if (r_rw) begin
                  r_rdata <= r_cap;
                  r_valid <= 1'b1;
               end
               r_shift <= '0;
               r_busy  <= w_queue;
               r_state <= w_queue ? S_GAP : S_IDLE;
            end
`ifdef SPI_START_QUEUE_EN
            S_GAP: begin
               // cs_n stays high through DONE plus CLK_DIV gap cycles before the queued frame.
               if (w_div_end) begin
                  r_div   <= '0;
                  r_shift <= r_pend_frame;
                  r_rw    <= r_pend_frame[FRAME_W-1];
                  r_cs_n  <= 1'b0;
                  r_bit   <= '0;
                  r_state <= S_SETUP;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_spi_sclk              = r_sclk;
   assign o_spi_cs_n              = r_cs_n;
   assign o_spi_mosi              = r_shift[FRAME_W-1];
   assign io_cmd.o_busy           = r_busy;
   assign io_cmd.o_spi_data_valid = r_valid;
   assign io_cmd.o_spi_rdata      = r_rdata;
endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: DUT0 at CLK_DIV=4, DUT1 at CLK_DIV=2, with a mode-0 slave/monitor per DUT.
module tb_spi_master_core;
   localparam int AW = 6;
   localparam int DW = 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_master_core_if #(.SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW)) if0();
   spi_master_core_if #(.SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW)) if1();

   logic [1:0] sclk, cs_n, mosi, miso, busy, valid;
   logic [DW-1:0] rdata [2];

   spi_master_core #(.SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW), .CLK_DIV(4)) u_dut0 (
      .i_clk_sys(clk), .i_rst(rst), .io_cmd(if0),
      .o_spi_sclk(sclk[0]), .o_spi_cs_n(cs_n[0]), .o_spi_mosi(mosi[0]), .i_spi_miso(miso[0]));
   spi_master_core #(.SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW), .CLK_DIV(2)) u_dut1 (
      .i_clk_sys(clk), .i_rst(rst), .io_cmd(if1),
      .o_spi_sclk(sclk[1]), .o_spi_cs_n(cs_n[1]), .o_spi_mosi(mosi[1]), .i_spi_miso(miso[1]));

   assign busy     = {if1.o_busy, if0.o_busy};
   assign valid    = {if1.o_spi_data_valid, if0.o_spi_data_valid};
   assign rdata[0] = if0.o_spi_rdata;
   assign rdata[1] = if1.o_spi_rdata;

   // Slave + bus monitor state, one slot per DUT.
   logic [DW-1:0] word_tab [2][4];
   logic [26:0] sreg [2]       = '{default: '0};
   logic [26:0] rec [2]        = '{default: '0};
   logic [26:0] last_frame [2] = '{default: '0};
   logic [26:0] prev_frame [2] = '{default: '0};
   logic [1:0]  prev_cs   = 2'b11;
   logic [1:0]  prev_sclk = 2'b00;
   logic [1:0]  prev_busy = 2'b00;
   int cyc = 0;
   int rise_cnt [2] = '{0, 0};
   int fall_cnt [2] = '{0, 0};
   int frame_cnt [2] = '{0, 0};
   int valid_cnt [2] = '{0, 0};
   int busy_falls [2] = '{0, 0};
   int cs_len_run [2] = '{0, 0};
   int last_cs_len [2] = '{0, 0};
   int gap_run [2] = '{0, 0};
   int last_gap [2] = '{0, 0};
   int last_rise_cyc [2] = '{0, 0};
   int last_period [2] = '{0, 0};
   int last_csrise_cyc [2] = '{0, 0};
   int last_valid_cyc [2] = '{0, 0};

   assign miso = {sreg[1][26], sreg[0][26]};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
         prev_cs[k]   <= cs_n[k];
         prev_sclk[k] <= sclk[k];
         prev_busy[k] <= busy[k];
         if (prev_cs[k] && !cs_n[k]) begin
            sreg[k]       <= {7'b0, word_tab[k][fall_cnt[k] % 4]};
            fall_cnt[k]   <= fall_cnt[k] + 1;
            last_gap[k]   <= gap_run[k];
            cs_len_run[k] <= 1;
         end else if (!cs_n[k]) begin
            cs_len_run[k] <= cs_len_run[k] + 1;
         end
         if (!prev_cs[k] && cs_n[k]) begin
            frame_cnt[k]       <= frame_cnt[k] + 1;
            prev_frame[k]      <= last_frame[k];
            last_frame[k]      <= rec[k];
            last_cs_len[k]     <= cs_len_run[k];
            last_csrise_cyc[k] <= cyc;
            gap_run[k]         <= 1;
         end else if (cs_n[k]) begin
            gap_run[k] <= gap_run[k] + 1;
         end
         if (prev_sclk[k] && !sclk[k]) sreg[k] <= {sreg[k][25:0], 1'b0};
         if (!prev_sclk[k] && sclk[k]) begin
            rise_cnt[k]      <= rise_cnt[k] + 1;
            rec[k]           <= {rec[k][25:0], mosi[k]};
            last_period[k]   <= cyc - last_rise_cyc[k];
            last_rise_cyc[k] <= cyc;
         end
         if (valid[k]) begin
            valid_cnt[k]      <= valid_cnt[k] + 1;
            last_valid_cyc[k] <= cyc;
         end
         if (prev_busy[k] && !busy[k]) busy_falls[k] <= busy_falls[k] + 1;
      end
   end

   int n_asrt = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled on the following posedge.
   task automatic cmd(input int k, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (k == 0) begin
         if0.i_spi_start = 1'b1; if0.i_spi_rw = rw; if0.i_spi_addr = a; if0.i_spi_wdata = d;
      end else begin
         if1.i_spi_start = 1'b1; if1.i_spi_rw = rw; if1.i_spi_addr = a; if1.i_spi_wdata = d;
      end
      @(negedge clk);
      if0.i_spi_start = 1'b0; if0.i_spi_addr = '1; if0.i_spi_wdata = '1; if0.i_spi_rw = 1'b1;
      if1.i_spi_start = 1'b0; if1.i_spi_addr = '1; if1.i_spi_wdata = '1; if1.i_spi_rw = 1'b1;
   endtask

   task automatic wait_idle(input int k, input int maxc, input string tag);
      int n = 0;
      while (busy[k] && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy[k]), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int r0, v0, f0, b0, n1;

   initial begin
      rst = 1'b1;
      if0.i_spi_start = 1'b0; if0.i_spi_rw = 1'b0; if0.i_spi_addr = '0; if0.i_spi_wdata = '0;
      if1.i_spi_start = 1'b0; if1.i_spi_rw = 1'b0; if1.i_spi_addr = '0; if1.i_spi_wdata = '0;
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 4; j++) word_tab[k][j] = '0;
      repeat (3) @(negedge clk);

      // Reset state on both instances
      for (int k = 0; k < 2; k++) begin
         chk("rst_sclk",  32'(sclk[k]),  32'd0);
         chk("rst_cs_n",  32'(cs_n[k]),  32'd1);
         chk("rst_mosi",  32'(mosi[k]),  32'd0);
         chk("rst_busy",  32'(busy[k]),  32'd0);
         chk("rst_valid", 32'(valid[k]), 32'd0);
         chk("rst_rdata", 32'(rdata[k]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // T1: write 0x2A <- 0xABCDE
      r0 = rise_cnt[0]; v0 = valid_cnt[0];
      cmd(0, 1'b0, 6'h2A, 20'hABCDE);
      chk("t1_busy_hi", 32'(busy[0]), 32'd1);
      chk("t1_cs_low",  32'(cs_n[0]), 32'd0);
      chk("t1_mosi0",   32'(mosi[0]), 32'd0);
      wait_idle(0, 400, "t1_timeout");
      repeat (2) @(negedge clk);
      chk("t1_frame",  32'(last_frame[0]), 32'(27'b0_101010_10101011110011011110));
      chk("t1_rises",  32'(rise_cnt[0] - r0), 32'd27);
      chk("t1_cs_len", 32'(last_cs_len[0]), 32'd224);
      chk("t1_novalid", 32'(valid_cnt[0] - v0), 32'd0);
      chk("t1_rdata",  32'(rdata[0]), 32'd0);
      chk("t1_mosi_idle", 32'(mosi[0]), 32'd0);

      // T2: read 0x05, slave returns 0x5A5A5
      word_tab[0][fall_cnt[0] % 4] = 20'h5A5A5;
      r0 = rise_cnt[0]; v0 = valid_cnt[0];
      cmd(0, 1'b1, 6'h05, 20'h12345);
      chk("t2_mosi0", 32'(mosi[0]), 32'd1);
      wait_idle(0, 400, "t2_timeout");
      chk("t2_valid", 32'(valid[0]), 32'd1);
      chk("t2_rdata", 32'(rdata[0]), 32'h5A5A5);
      repeat (2) @(negedge clk);
      chk("t2_valid_low",  32'(valid[0]), 32'd0);
      chk("t2_valid_cnt",  32'(valid_cnt[0] - v0), 32'd1);
      chk("t2_valid_lag",  32'(last_valid_cyc[0] - last_csrise_cyc[0]), 32'd1);
      chk("t2_frame", 32'(last_frame[0]), 32'({1'b1, 6'h05, 20'h00000}));
      chk("t2_rises", 32'(rise_cnt[0] - r0), 32'd27);

      // T3/T4: second start 50 cycles into a write frame
      r0 = rise_cnt[0]; f0 = frame_cnt[0]; b0 = busy_falls[0];
      cmd(0, 1'b0, 6'h11, 20'h12345);
      repeat (49) @(negedge clk);
      cmd(0, 1'b0, 6'h22, 20'h6789A);
      wait_idle(0, 800, "t3_timeout");
      repeat (20) @(negedge clk);
      chk("t3_busy_falls", 32'(busy_falls[0] - b0), 32'd1);
      chk("t3_rdata", 32'(rdata[0]), 32'h5A5A5);
`ifdef SPI_START_QUEUE_EN
      chk("t4_frames", 32'(frame_cnt[0] - f0), 32'd2);
      chk("t4_rises",  32'(rise_cnt[0] - r0), 32'd54);
      chk("t4_frame_a", 32'(prev_frame[0]), 32'({1'b0, 6'h11, 20'h12345}));
      chk("t4_frame_b", 32'(last_frame[0]), 32'({1'b0, 6'h22, 20'h6789A}));
      chk("t4_gap_ge",  32'(last_gap[0] >= 4), 32'd1);
      chk("t4_cs_len",  32'(last_cs_len[0]), 32'd224);
`else
      chk("t3_frames", 32'(frame_cnt[0] - f0), 32'd1);
      chk("t3_rises",  32'(rise_cnt[0] - r0), 32'd27);
      chk("t3_frame_a", 32'(last_frame[0]), 32'({1'b0, 6'h11, 20'h12345}));
`endif

      // T5: reset during bit 10 of a read, then a clean write
      word_tab[0][fall_cnt[0] % 4] = 20'hC3C3C;
      r0 = rise_cnt[0];
      cmd(0, 1'b1, 6'h15, 20'h0);
      n1 = 0;
      while (rise_cnt[0] - r0 < 11 && n1 < 400) begin
         @(negedge clk);
         n1++;
      end
      chk("t5_reach_bit10", 32'(rise_cnt[0] - r0 >= 11), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_cs_n", 32'(cs_n[0]), 32'd1);
      chk("t5_sclk", 32'(sclk[0]), 32'd0);
      chk("t5_busy", 32'(busy[0]), 32'd0);
      chk("t5_mosi", 32'(mosi[0]), 32'd0);
      rst = 1'b0;
      v0 = valid_cnt[0];
      repeat (10) @(negedge clk);
      chk("t5_novalid", 32'(valid_cnt[0] - v0), 32'd0);
      chk("t5_rdata_clr", 32'(rdata[0]), 32'd0);
      r0 = rise_cnt[0]; v0 = valid_cnt[0];
      cmd(0, 1'b0, 6'h01, 20'h0F0F0);
      wait_idle(0, 400, "t5_timeout");
      repeat (2) @(negedge clk);
      chk("t5_frame",  32'(last_frame[0]), 32'({1'b0, 6'h01, 20'h0F0F0}));
      chk("t5_rises",  32'(rise_cnt[0] - r0), 32'd27);
      chk("t5_cs_len", 32'(last_cs_len[0]), 32'd224);
      chk("t5_wr_novalid", 32'(valid_cnt[0] - v0), 32'd0);

      // T6: CLK_DIV=2, back-to-back reads
      word_tab[1][fall_cnt[1] % 4]       = 20'h00001;
      word_tab[1][(fall_cnt[1] + 1) % 4] = 20'hFFFFF;
      f0 = frame_cnt[1];
      cmd(1, 1'b1, 6'h03, 20'h0);
      wait_idle(1, 300, "t6_timeout_a");
      chk("t6_valid_a", 32'(valid[1]), 32'd1);
      chk("t6_rdata_a", 32'(rdata[1]), 32'h00001);
      cmd(1, 1'b1, 6'h07, 20'h0);
      chk("t6_accept_b", 32'(busy[1]), 32'd1);
      wait_idle(1, 300, "t6_timeout_b");
      chk("t6_valid_b", 32'(valid[1]), 32'd1);
      chk("t6_rdata_b", 32'(rdata[1]), 32'hFFFFF);
      repeat (2) @(negedge clk);
      chk("t6_frames", 32'(frame_cnt[1] - f0), 32'd2);
      chk("t6_period", 32'(last_period[1]), 32'd4);
      chk("t6_frame_b", 32'(last_frame[1]), 32'({1'b1, 6'h07, 20'h00000}));
      chk("t6_cs_len", 32'(last_cs_len[1]), 32'd112);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
- Serial SPI master directly downstream of the UART/SPI command controller.
- Consumes one-cycle start/rw/addr/data commands and shifts a 27-bit frame out on a mode-0 SPI bus: R/W bit, 6-bit address, 20-bit data.
- On read frames, returns the captured 20-bit register word with a one-cycle valid pulse.
- The controller has no busy input, so this block owns all collision handling.

Parameters:
SPI_ADDR_WIDTH, 6, address field width
SPI_DATA_WIDTH, 20, data field width
CLK_DIV, 4, SCLK half-period in i_clk_sys cycles (legal >= 2); SCLK = f_sys/(2*CLK_DIV)

Ports:
i_clk_sys  in  1  system clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_spi_start  in  1  one-cycle command strobe
i_spi_rw  in  1  1 = read, 0 = write; sampled with start
i_spi_addr  in  SPI_ADDR_WIDTH  register address; sampled with start
i_spi_wdata  in  SPI_DATA_WIDTH  write data; sampled with start
o_spi_data_valid  out  1  one-cycle pulse, read data ready
o_spi_rdata  out  SPI_DATA_WIDTH  captured read word, held until next read completes
o_busy  out  1  high from the cycle after start is accepted until return to IDLE
o_spi_sclk  out  1  SPI clock, CPOL=0
o_spi_cs_n  out  1  chip select, active-low
o_spi_mosi  out  1  master out, MSB first
i_spi_miso  in  1  master in; treated as synchronous to i_clk_sys, no synchroniser

Behaviour:
- Reset values:
  - sclk = 0, cs_n = 1, mosi = 0
  - busy = 0, data_valid = 0, rdata = 0
  - state = IDLE, all counters = 0
- Frame, MSB first: bit26 = rw, bits25:20 = addr, bits19:0 = wdata.
  - On reads, the data field is shifted out as 0.
  - Frame length = 1 + SPI_ADDR_WIDTH + SPI_DATA_WIDTH.
- IDLE:
  - start = 1 latches rw/addr/wdata into the shift register.
  - Next cycle: cs_n = 0, mosi = frame bit26, busy = 1; go to SETUP.
- SETUP: hold sclk = 0 for CLK_DIV cycles, then enter SHIFT.
- SHIFT, per bit:
  - CLK_DIV cycles with sclk = 0, then CLK_DIV cycles with sclk = 1.
  - The cycle sclk rises, MISO is sampled into the capture register (bit index = frame index).
  - The cycle sclk falls, mosi advances to the next bit.
  - After the last high phase, sclk returns to 0; go to HOLD.
- HOLD: cs_n stays 0 for CLK_DIV cycles, then cs_n = 1; go to DONE.
- DONE (1 cycle):
  - Read frame: rdata <= last 20 captured bits, data_valid = 1.
  - Write frame: no valid pulse, rdata unchanged.
  - mosi = 0, busy = 0 next cycle; go to IDLE.
- Timing:
  - CS low duration = CLK_DIV*(2 + 2*27) cycles: 224 at CLK_DIV=4.
  - data_valid asserts 1 cycle after cs_n rises.
- start while busy (SETUP..DONE): dropped, no state change (see optional feature).
- start in the same cycle DONE exits: dropped; accepted only when state = IDLE.
- Reset mid-frame: outputs return to reset values on the next edge; the bus is abandoned and no valid pulse is produced.
- Address/data inputs are ignored except on the start-accept cycle.
- Counters: bit counter 5 bits, divide counter $clog2(CLK_DIV) bits. Both wrap only under FSM control.

Optional Feature:
- Macro: SPI_START_QUEUE_EN.
- Defined: a one-deep pending register captures the first start (with rw/addr/wdata) arriving while not IDLE.
  - Later starts while pending are dropped.
  - From DONE, the FSM goes straight to the accept path.
  - cs_n is held high for at least CLK_DIV cycles between frames, then the queued frame is issued.
  - busy stays 1 across both frames.
  - Reset clears the pending register.
- Undefined: busy-time starts are dropped, as above.

Test Plan:
1. CLK_DIV=4, write rw=0 addr=0x2A wdata=0xABCDE -> MOSI bit stream 0_101010_10101011110011011110; 27 sclk rising edges; cs_n low 224 cycles; no data_valid; busy falls after DONE.
2. Read rw=1 addr=0x05, slave model drives MISO = 0x5A5A5 in the data phase -> MOSI = 1_000101 then 20 zeros; o_spi_rdata = 0x5A5A5; data_valid is a single pulse 1 cycle after cs_n rises.
3. Second start 50 cycles into a frame, macro undefined -> ignored; only one frame on the bus; rdata unchanged.
4. Same as 3 with SPI_START_QUEUE_EN -> second frame follows; cs_n high >= CLK_DIV cycles between frames; both frames bit-exact; busy continuous.
5. i_rst pulsed during bit 10 of a read -> next edge: cs_n = 1, sclk = 0, busy = 0; no data_valid; a following write to 0x01 completes normally.
6. CLK_DIV=2, back-to-back reads with start issued the cycle after busy falls -> both accepted; sclk period = 4 cycles; each read returns its own slave word (0x00001, 0xFFFFF).
